// File: rtl/stim_sweep_pkg.sv
// Shared types and MISR step function for the exhaustive stimulus sweep.
// Consumed by stim_sweep_capture and misr_compactor.
package stim_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    COMPARE,
    DONE
  } state_t;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

  // Signature width w is at most 63 so the mask below never overflows.
  function automatic logic [63:0] misr_step(input logic [63:0] sig,
                                            input logic [63:0] word,
                                            input logic [63:0] poly,
                                            input int          w);
    logic [63:0] mask;
    logic [63:0] fb;
    mask = (64'd1 << w) - 64'd1;
    fb   = (((sig >> (w - 1)) & 64'd1) != 64'd0) ? poly : 64'd0;
    return ((sig << 1) ^ fb ^ word) & mask;
  endfunction

endpackage

// File: rtl/misr_compactor.sv
// Multiple-input signature register: folds one data word per enabled cycle.
// clear has priority over enable.
module misr_compactor
  import stim_sweep_pkg::*;
#(
  parameter int                MISR_W = 16,
  parameter int                DW     = 3,
  parameter logic [MISR_W-1:0] POLY   = DEFAULT_POLY
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              enable,
  input  logic [DW-1:0]     data,
  output logic [MISR_W-1:0] signature
);

  always_ff @(posedge clk) begin
    if (clear) begin
      signature <= '0;
    end else if (enable) begin
      signature <= MISR_W'(misr_step(64'(signature), 64'(data), 64'(POLY), MISR_W));
    end
  end

endmodule

// File: rtl/stim_sweep_capture.sv
// Drives every input pattern into a benchmark DUT, captures {pattern, response}
// pairs, compacts them into a MISR signature and flags a golden mismatch.
module stim_sweep_capture
  import stim_sweep_pkg::*;
#(
  parameter int                N_IN   = 2,
  parameter int                N_OUT  = 1,
  parameter int                HOLD   = 2,
  parameter int                MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY   = DEFAULT_POLY
) (
  input  logic                  CK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MISR_W-1:0]     golden_sig,
  input  logic [N_OUT-1:0]      dut_out,
  output logic [N_IN-1:0]       dut_in,
  output logic                  busy,
  output logic                  done,
  output logic                  mismatch,
  output logic [MISR_W-1:0]     signature,
  input  logic [$clog2(2**N_IN)-1:0] rd_addr,
  output logic [N_IN+N_OUT-1:0] rd_data
);

  localparam int DEPTH = 2 ** N_IN;
  localparam int DW    = N_IN + N_OUT;
  localparam int HW    = $clog2(HOLD + 1);

  state_t          state;
  logic [N_IN-1:0] pat;
  logic [HW-1:0]   hold;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   word;
  logic            sample;
  logic            launch;

  assign word   = {pat, dut_out};
  assign sample = (state == APPLY) && (hold == HW'(HOLD - 1));
  assign launch = start && ((state == IDLE) || (state == DONE));
  assign dut_in = pat;
  assign rd_data = mem[rd_addr];

  misr_compactor #(
    .MISR_W (MISR_W),
    .DW     (DW),
    .POLY   (POLY)
  ) u_misr (
    .clk       (CK),
    .clear     (reset | launch),
    .enable    (sample),
    .data      (word),
    .signature (signature)
  );

  always_ff @(posedge CK) begin
    if (reset) begin
      state    <= IDLE;
      pat      <= '0;
      hold     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= APPLY;
            pat      <= '0;
            hold     <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            mismatch <= 1'b0;
          end
        end
        APPLY: begin
          if (sample) begin
            mem[pat] <= word;
            hold     <= '0;
            // pat stays at the last pattern so dut_in holds DEPTH-1 afterwards.
            if (pat == '1) state <= COMPARE;
            else           pat   <= pat + 1'b1;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        COMPARE: begin
          mismatch <= (signature != golden_sig);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stim_sweep_capture.md
Name: stim_sweep_capture

Overview:
- Benchmark-side sequencer for the trojan-detection flow.
- Drives every input pattern 0..2**N_IN-1 into a benchmark DUT and holds each pattern for HOLD cycles.
- Samples the DUT response at the end of each hold and stores the {pattern, response} pairs in a readable capture buffer.
- Compacts the pairs into a MISR signature and compares that signature against a golden value, raising a mismatch (trojan suspect) flag.

Parameters:
- N_IN, 2, DUT input width; DEPTH = 2**N_IN patterns.
- N_OUT, 1, DUT output width; capture word width DW = N_IN+N_OUT.
- HOLD, 2, cycles each pattern is held (must be >= 1).
- MISR_W, 16, signature width (must be >= DW).
- POLY, 16'h1021, MISR feedback polynomial.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a sweep when in IDLE or DONE; ignored while busy.
- golden_sig  in  MISR_W  expected signature; sampled in COMPARE.
- dut_out  in  N_OUT  DUT response.
- dut_in  out  N_IN  pattern driven to the DUT.
- busy  out  1  high from the start edge until the COMPARE edge.
- done  out  1  sweep complete; held until the next start or reset.
- mismatch  out  1  signature != golden_sig; valid when done=1.
- signature  out  MISR_W  current MISR value.
- rd_addr  in  $clog2(DEPTH)  capture buffer read address.
- rd_data  out  DW  combinational read: {pattern, response} at rd_addr.

Behaviour:
- Reset (CK edge with reset=1):
  - state IDLE; dut_in, busy, done, mismatch and signature = 0.
  - pattern counter = 0; hold counter = 0; all capture entries = 0.
  - reset overrides start and aborts any sweep in progress, returning to IDLE the following cycle.
- States: IDLE, APPLY, COMPARE, DONE.
- IDLE/DONE, start=1 at edge E0:
  - go to APPLY; pat=0, hold=0, signature=0, busy=1, done=0, mismatch=0.
- APPLY:
  - dut_in = pat (registered).
  - hold increments each edge.
  - At the edge where hold == HOLD-1 (first at E0+HOLD): capture dut_out.
    - mem[pat] <= {pat, dut_out}.
    - signature <= {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? POLY : 0) ^ zero_ext({pat, dut_out}).
    - hold <= 0.
    - If pat == DEPTH-1, go to COMPARE; otherwise pat <= pat+1, so dut_in changes on the same edge.
  - HOLD=1: a sample occurs every edge.
  - The last sample is at E0 + DEPTH*HOLD.
- COMPARE (one cycle):
  - At edge E0 + DEPTH*HOLD + 1: mismatch <= (signature != golden_sig); done <= 1; busy <= 0; go to DONE.
- DONE:
  - Outputs stable; dut_in holds DEPTH-1.
  - start restarts exactly as from IDLE.
  - mem is not cleared on restart; entries are overwritten.
- start=1 during APPLY or COMPARE: no effect.
- Counters: pat is $clog2(DEPTH) bits and never wraps within a sweep. The hold counter is $clog2(HOLD+1) bits.
- rd_data is readable at any time; values are stable once a sample has been written.

Decomposition:
- Package stim_sweep_pkg:
  - state enum (IDLE, APPLY, COMPARE, DONE).
  - function misr_step(sig, word, poly) implementing the MISR update above.
  - default POLY constant.
- One sub-module: misr_compactor, with clear/enable/data in and signature out, built on misr_step.
- The capture buffer stays inline as a flop array.

Test Plan:
- DUT = AND2 (N_IN=2, HOLD=2), golden_sig=16'h0007, start pulse:
  - dut_in sequence 0,1,2,3 for 2 cycles each.
  - Words 3'b000, 3'b010, 3'b100, 3'b111 captured.
  - signature = 16'h0007; done=1 at E0+9; mismatch=0.
- Trojan DUT stuck-at-0, same golden:
  - mem[3] = 3'b110; signature = 16'h0006; mismatch=1.
- Reset asserted at E0+5 mid-sweep:
  - next cycle state IDLE; busy, done and dut_in = 0; all rd_data = 0.
  - A fresh start then reproduces the AND2 result.
- start pulsed repeatedly during APPLY:
  - no restart; timing is identical to the first scenario.
  - In DONE, start reclears done and repeats the sweep with the same signature.
- HOLD=1 with AND2:
  - samples on consecutive edges; done at E0+5; signature = 16'h0007.
